alarm_sequencer: RTL

- Controller between raw fire-panel sensors (temperature, smoke) and alarm indicator/display logic.
- Synchronises and debounces both sensor inputs, then sequences the alarm through a state machine: idle, sounding, silenced by operator acknowledge, and timed clear.
- Drives a latched 2-bit alarm cause code, an alarm-active flag and a pulsed buzzer for downstream 7-segment/LED drivers.

---
 rtl/alarm_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alarm_sequencer.sv
// Fire-panel alarm sequencer: two-flop sync + debounce per sensor, then IDLE/ALARM/SILENCED/CLEAR FSM.
// Optional macro ALARM_EVENT_COUNT_EN builds a saturating IDLE->ALARM event counter on Event_cnt_o.
module alarm_sequencer #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int BUZZ_HALF   = 2,
  parameter int CNT_W       = 8
) (
  input  logic       CLK_clk_i,
  input  logic       RST_rst_i,
  input  logic       Sensor_Temp_i,
  input  logic       Sensor_Humo_i,
  input  logic       Ack_i,
  output logic [1:0] Alarm_code_o,
  output logic       Alarm_active_o,
  output logic       Buzzer_o,
  output logic [7:0] Event_cnt_o
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUZZ_LAST = CNT_W'(BUZZ_HALF - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ALARM, ST_SILENCED, ST_CLEAR} state_t;

  logic [1:0] raw;
  logic [1:0] filt;
  logic       act;
  logic [1:0] new_cause;

  assign raw = {Sensor_Humo_i, Sensor_Temp_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sensor
      logic             sync1_reg;
      logic             sync2_reg;
      logic             filt_reg;
      logic [CNT_W-1:0] deb_cnt_reg;

      // filt only follows sync2 after DEB_CYCLES consecutive disagreeing cycles
      always_ff @(posedge CLK_clk_i or posedge RST_rst_i) begin
        if (RST_rst_i) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          filt_reg    <= 1'b0;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            filt_reg    <= sync2_reg;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + CNT_W'(1);
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  assign act       = |filt;
  assign new_cause = filt & ~Alarm_code_o;

  state_t           state_reg;
  logic [1:0]       code_reg;
  logic             active_reg;
  logic             buzzer_reg;
  logic [CNT_W-1:0] buzz_cnt_reg;
  logic [CNT_W-1:0] hold_cnt_reg;

  always_ff @(posedge CLK_clk_i or posedge RST_rst_i) begin
    if (RST_rst_i) begin
      state_reg    <= ST_IDLE;
      code_reg     <= 2'b00;
      active_reg   <= 1'b0;
      buzzer_reg   <= 1'b0;
      buzz_cnt_reg <= '0;
      hold_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (act) begin
            state_reg    <= ST_ALARM;
            code_reg     <= filt;
            active_reg   <= 1'b1;
            buzzer_reg   <= 1'b1;
            buzz_cnt_reg <= '0;
          end
        end
        ST_ALARM: begin
          code_reg <= code_reg | filt;
          if (buzz_cnt_reg == BUZZ_LAST) begin
            buzzer_reg   <= ~buzzer_reg;
            buzz_cnt_reg <= '0;
          end else begin
            buzz_cnt_reg <= buzz_cnt_reg + CNT_W'(1);
          end
          // A fresh cause alongside Ack keeps sounding; Ack only silences known causes
          if (!act) begin
            state_reg    <= ST_CLEAR;
            buzzer_reg   <= 1'b0;
            hold_cnt_reg <= '0;
          end else if (Ack_i && (new_cause == 2'b00)) begin
            state_reg  <= ST_SILENCED;
            buzzer_reg <= 1'b0;
          end
        end
        ST_SILENCED: begin
          if (new_cause != 2'b00) begin
            state_reg    <= ST_ALARM;
            code_reg     <= code_reg | new_cause;
            buzzer_reg   <= 1'b1;
            buzz_cnt_reg <= '0;
          end else if (!act) begin
            state_reg    <= ST_CLEAR;
            hold_cnt_reg <= '0;
          end
        end
        ST_CLEAR: begin
          if (act) begin
            state_reg    <= ST_ALARM;
            code_reg     <= code_reg | filt;
            buzzer_reg   <= 1'b1;
            buzz_cnt_reg <= '0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_reg    <= ST_IDLE;
            code_reg     <= 2'b00;
            active_reg   <= 1'b0;
            hold_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign Alarm_code_o   = code_reg;
  assign Alarm_active_o = active_reg;
  assign Buzzer_o       = buzzer_reg;

`ifdef ALARM_EVENT_COUNT_EN
  logic [7:0] evt_cnt_reg;

  // Counts fresh episodes only; escalations and CLEAR re-entries leave it alone
  always_ff @(posedge CLK_clk_i or posedge RST_rst_i) begin
    if (RST_rst_i) begin
      evt_cnt_reg <= 8'd0;
    end else if ((state_reg == ST_IDLE) && act && (evt_cnt_reg != 8'hFF)) begin
      evt_cnt_reg <= evt_cnt_reg + 8'd1;
    end
  end

  assign Event_cnt_o = evt_cnt_reg;
`else
  assign Event_cnt_o = 8'd0;
`endif

endmodule
